// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer and the rename stage that feeds it.
package reorder_buffer_pkg;

    localparam int ROB_LENGTH = 32;
    localparam int ROB_TAG_W  = 5;
    localparam int ROB_PREG_W = 6;
    localparam int ARCH_W     = 5;
    localparam int PC_W       = 32;

    // Retire-side bundles seen by rename: {strobe, arch_reg, new_phys} and {strobe, old_phys}
    localparam int RRAT_UPD_W = 1 + ARCH_W + ROB_PREG_W;
    localparam int FREE_UPD_W = 1 + ROB_PREG_W;

    // Architectural r0 is hardwired, so it never updates the RRAT nor frees a register.
    function automatic logic writes_arch_reg(input logic regwrite, input logic [ARCH_W-1:0] arch_reg);
        return regwrite && (arch_reg != {ARCH_W{1'b0}});
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/EXE/retire signal bundle of the reorder buffer; the ROB is the slave side.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W  = ROB_TAG_W,
    parameter int PREG_W = ROB_PREG_W
);

    logic              alloc_valid;
    logic              alloc_regwrite;
    logic [ARCH_W-1:0] alloc_arch_reg;
    logic [PREG_W-1:0] alloc_new_phys;
    logic [PREG_W-1:0] alloc_old_phys;
    logic [PC_W-1:0]   alloc_pc;
    logic              rob_halt;
    logic [TAG_W-1:0]  alloc_tag;

    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic              complete_mispredict;
    logic [PC_W-1:0]   complete_target;

    logic              retire_valid;
    logic              retire_regwrite;
    logic [ARCH_W-1:0] retire_arch_reg;
    logic [PREG_W-1:0] retire_new_phys;
    logic              free_valid;
    logic [PREG_W-1:0] free_phys;
    logic [PC_W-1:0]   retire_pc;
    logic              flush;
    logic [PC_W-1:0]   flush_target;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_regwrite, alloc_arch_reg, alloc_new_phys, alloc_old_phys, alloc_pc,
        output complete_valid, complete_tag, complete_mispredict, complete_target,
        input  rob_halt, alloc_tag, retire_valid, retire_regwrite, retire_arch_reg, retire_new_phys,
        input  free_valid, free_phys, retire_pc, flush, flush_target, count
    );

    modport slave (
        input  alloc_valid, alloc_regwrite, alloc_arch_reg, alloc_new_phys, alloc_old_phys, alloc_pc,
        input  complete_valid, complete_tag, complete_mispredict, complete_target,
        output rob_halt, alloc_tag, retire_valid, retire_regwrite, retire_arch_reg, retire_new_phys,
        output free_valid, free_phys, retire_pc, flush, flush_target, count
    );

endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: tail allocation from rename, completion by tag from EXE, in-order
// retirement toward the RRAT and free list, and a one-cycle flush on a mispredicted head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int LENGTH = ROB_LENGTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int PREG_W = ROB_PREG_W
) (
    input logic             CLK,
    input logic             RESET,
    reorder_buffer_if.slave bus
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    logic [LENGTH-1:0]   r_valid;
    logic [LENGTH-1:0]   r_done;

    logic                r_mispredict [LENGTH];
    logic                r_regwrite   [LENGTH];
    logic [ARCH_W-1:0]   r_arch_reg   [LENGTH];
    logic [PREG_W-1:0]   r_new_phys   [LENGTH];
    logic [PREG_W-1:0]   r_old_phys   [LENGTH];
    logic [PC_W-1:0]     r_pc         [LENGTH];
    logic [PC_W-1:0]     r_target     [LENGTH];

    logic                r_retire_valid;
    logic                r_retire_regwrite;
    logic [ARCH_W-1:0]   r_retire_arch_reg;
    logic [PREG_W-1:0]   r_retire_new_phys;
    logic                r_free_valid;
    logic [PREG_W-1:0]   r_free_phys;
    logic [PC_W-1:0]     r_retire_pc;
    logic                r_flush;
    logic [PC_W-1:0]     r_flush_target;

    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic                w_full;
    logic                w_retire;
    logic                w_retire_writes;
    logic                w_flush_pending;
    logic                w_alloc;
    logic                w_complete;

    // Status, retire decision and request acceptance, all from start-of-cycle state.
    always_comb begin
        w_head_idx      = r_head[TAG_W-1:0];
        w_tail_idx      = r_tail[TAG_W-1:0];
        w_full          = (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]) && (r_head[TAG_W] != r_tail[TAG_W]);
        w_retire        = r_valid[w_head_idx] && r_done[w_head_idx];
        w_retire_writes = w_retire && writes_arch_reg(r_regwrite[w_head_idx], r_arch_reg[w_head_idx]);
        w_flush_pending = w_retire && r_mispredict[w_head_idx];
        w_alloc         = bus.alloc_valid && !w_full && !w_flush_pending;
        w_complete      = bus.complete_valid && r_valid[bus.complete_tag] && !w_flush_pending;
    end

    // Occupancy bookkeeping: pointers plus per-entry valid/done.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_head  <= {(TAG_W+1){1'b0}};
            r_tail  <= {(TAG_W+1){1'b0}};
            r_valid <= {LENGTH{1'b0}};
            r_done  <= {LENGTH{1'b0}};
        end else if (w_flush_pending) begin
            r_head  <= {(TAG_W+1){1'b0}};
            r_tail  <= {(TAG_W+1){1'b0}};
            r_valid <= {LENGTH{1'b0}};
            r_done  <= {LENGTH{1'b0}};
        end else begin
            if (w_alloc) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + (TAG_W+1)'(1);
            end
            if (w_complete) begin
                r_done[bus.complete_tag] <= 1'b1;
            end
            // Placed last so a retiring head is always cleared even if re-completed.
            if (w_retire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + (TAG_W+1)'(1);
            end
        end
    end

    // Entry payload; only ever read once valid/done qualify it, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_alloc) begin
            r_regwrite[w_tail_idx] <= bus.alloc_regwrite;
            r_arch_reg[w_tail_idx] <= bus.alloc_arch_reg;
            r_new_phys[w_tail_idx] <= bus.alloc_new_phys;
            r_old_phys[w_tail_idx] <= bus.alloc_old_phys;
            r_pc[w_tail_idx]       <= bus.alloc_pc;
        end
        if (w_complete) begin
            r_mispredict[bus.complete_tag] <= bus.complete_mispredict;
            r_target[bus.complete_tag]     <= bus.complete_target;
        end
    end

    // Registered retire, free-list and flush outputs; all fields read zero when idle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_retire_valid    <= 1'b0;
            r_retire_regwrite <= 1'b0;
            r_retire_arch_reg <= {ARCH_W{1'b0}};
            r_retire_new_phys <= {PREG_W{1'b0}};
            r_free_valid      <= 1'b0;
            r_free_phys       <= {PREG_W{1'b0}};
            r_retire_pc       <= {PC_W{1'b0}};
            r_flush           <= 1'b0;
            r_flush_target    <= {PC_W{1'b0}};
        end else begin
            r_retire_valid    <= w_retire;
            r_retire_regwrite <= w_retire_writes;
            r_free_valid      <= w_retire_writes;
            r_flush           <= w_flush_pending;
            r_retire_arch_reg <= w_retire ? r_arch_reg[w_head_idx] : {ARCH_W{1'b0}};
            r_retire_new_phys <= w_retire ? r_new_phys[w_head_idx] : {PREG_W{1'b0}};
            r_free_phys       <= w_retire ? r_old_phys[w_head_idx] : {PREG_W{1'b0}};
            r_retire_pc       <= w_retire ? r_pc[w_head_idx] : {PC_W{1'b0}};
            r_flush_target    <= w_flush_pending ? r_target[w_head_idx] : {PC_W{1'b0}};
        end
    end

    assign bus.rob_halt        = w_full;
    assign bus.alloc_tag       = w_tail_idx;
    assign bus.count           = r_tail - r_head;
    assign bus.retire_valid    = r_retire_valid;
    assign bus.retire_regwrite = r_retire_regwrite;
    assign bus.retire_arch_reg = r_retire_arch_reg;
    assign bus.retire_new_phys = r_retire_new_phys;
    assign bus.free_valid      = r_free_valid;
    assign bus.free_phys       = r_free_phys;
    assign bus.retire_pc       = r_retire_pc;
    assign bus.flush           = r_flush;
    assign bus.flush_target    = r_flush_target;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: program-order queue model, directed scenarios, random traffic.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(5), .PREG_W(6)) bus ();

    reorder_buffer dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        done;
        logic        mis;
        logic        rw;
        logic [4:0]  arch;
        logic [5:0]  np;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    // Model: occupied entries in program order; q[0] is the oldest. m_head is its sequence number mod 64.
    ent_t q[$];
    int   m_head = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    logic        e_rv, e_rrw, e_fv, e_fl;
    logic [4:0]  e_arch;
    logic [5:0]  e_np, e_fp;
    logic [31:0] e_pc, e_ft;

    logic        r_av, r_rw, r_cv, r_cm;
    logic [4:0]  r_ar, r_ct;
    logic [5:0]  r_np, r_op;
    logic [31:0] r_pc, r_tg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("retire_valid",    32'(bus.retire_valid),    32'(e_rv));
        chk("retire_regwrite", 32'(bus.retire_regwrite), 32'(e_rrw));
        chk("retire_arch_reg", 32'(bus.retire_arch_reg), 32'(e_arch));
        chk("retire_new_phys", 32'(bus.retire_new_phys), 32'(e_np));
        chk("free_valid",      32'(bus.free_valid),      32'(e_fv));
        chk("free_phys",       32'(bus.free_phys),       32'(e_fp));
        chk("retire_pc",       bus.retire_pc,            e_pc);
        chk("flush",           32'(bus.flush),           32'(e_fl));
        chk("flush_target",    bus.flush_target,         e_ft);
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic step(input logic av, input logic rw, input logic [4:0] ar, input logic [5:0] np,
                        input logic [5:0] op, input logic [31:0] pc, input logic cv, input logic [4:0] ct,
                        input logic cm, input logic [31:0] tg);
        int   sz;
        int   p;
        logic ret;
        logic fl;
        ent_t e;
        bus.alloc_valid = av;          bus.alloc_regwrite = rw;
        bus.alloc_arch_reg = ar;       bus.alloc_new_phys = np;
        bus.alloc_old_phys = op;       bus.alloc_pc = pc;
        bus.complete_valid = cv;       bus.complete_tag = ct;
        bus.complete_mispredict = cm;  bus.complete_target = tg;
        #1;
        sz = q.size();
        chk("rob_halt",  32'(bus.rob_halt),  32'(sz == 32));
        chk("alloc_tag", 32'(bus.alloc_tag), 32'((m_head + sz) % 32));
        chk("count",     32'(bus.count),     32'(sz));
        @(posedge clk);
        ret = (sz > 0) && q[0].done;
        fl  = ret && q[0].mis;
        if (ret) begin
            e_rv = 1'b1;  e_rrw = q[0].rw && (q[0].arch != 5'd0);  e_fv = e_rrw;
            e_arch = q[0].arch;  e_np = q[0].np;  e_fp = q[0].op;  e_pc = q[0].pc;
        end else begin
            e_rv = 1'b0;  e_rrw = 1'b0;  e_fv = 1'b0;
            e_arch = 5'd0;  e_np = 6'd0;  e_fp = 6'd0;  e_pc = 32'd0;
        end
        e_fl = fl;
        e_ft = fl ? q[0].tgt : 32'd0;
        if (fl) begin
            q.delete();
            m_head = 0;
        end else begin
            if (cv) begin
                p = (int'(ct) - (m_head % 32) + 32) % 32;
                if (p < sz) begin
                    q[p].done = 1'b1;  q[p].mis = cm;  q[p].tgt = tg;
                end
            end
            if (ret) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % 64;
            end
            if (av && sz < 32) begin
                e.done = 1'b0;  e.mis = 1'b0;  e.rw = rw;  e.arch = ar;
                e.np = np;  e.op = op;  e.pc = pc;  e.tgt = 32'd0;
                q.push_back(e);
            end
        end
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic alloc(input logic rw, input logic [4:0] ar, input logic [5:0] np, input logic [5:0] op,
                         input logic [31:0] pc);
        step(1'b1, rw, ar, np, op, pc, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic comp(input logic [4:0] ct, input logic cm, input logic [31:0] tg);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 32'd0, 1'b1, ct, cm, tg);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    // Asynchronous reset dropped between clock edges; outputs must clear at once.
    task automatic do_reset();
        bus.alloc_valid = 1'b0;     bus.alloc_regwrite = 1'b0;  bus.alloc_arch_reg = 5'd0;
        bus.alloc_new_phys = 6'd0;  bus.alloc_old_phys = 6'd0;  bus.alloc_pc = 32'd0;
        bus.complete_valid = 1'b0;  bus.complete_tag = 5'd0;    bus.complete_mispredict = 1'b0;
        bus.complete_target = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_head = 0;
        e_rv = 1'b0;  e_rrw = 1'b0;  e_fv = 1'b0;  e_fl = 1'b0;
        e_arch = 5'd0;  e_np = 6'd0;  e_fp = 6'd0;  e_pc = 32'd0;  e_ft = 32'd0;
        check_regs();
        chk("reset_count",    32'(bus.count),    32'd0);
        chk("reset_rob_halt", 32'(bus.rob_halt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single alloc -> complete -> retire two cycles after the alloc edge.
        alloc(1'b1, 5'd8, 6'd40, 6'd8, 32'h0040_0000);
        comp(5'd0, 1'b0, 32'd0);
        idle();
        chk("t1_retire_valid", 32'(bus.retire_valid),    32'd1);
        chk("t1_regwrite",     32'(bus.retire_regwrite), 32'd1);
        chk("t1_arch",         32'(bus.retire_arch_reg), 32'd8);
        chk("t1_new_phys",     32'(bus.retire_new_phys), 32'd40);
        chk("t1_free_phys",    32'(bus.free_phys),       32'd8);
        chk("t1_retire_pc",    bus.retire_pc,            32'h0040_0000);
        chk("t1_count",        32'(bus.count),           32'd0);

        // Out-of-order completion 2,0,1 retires strictly in order 0,1,2.
        do_reset();
        alloc(1'b1, 5'd1, 6'd33, 6'd1, 32'h100);
        alloc(1'b1, 5'd2, 6'd34, 6'd2, 32'h104);
        alloc(1'b1, 5'd3, 6'd35, 6'd3, 32'h108);
        comp(5'd2, 1'b0, 32'd0);
        comp(5'd0, 1'b0, 32'd0);
        chk("t2_no_retire_yet", 32'(bus.retire_valid), 32'd0);
        comp(5'd1, 1'b0, 32'd0);
        chk("t2_first_pc", bus.retire_pc, 32'h100);
        idle();
        chk("t2_second_pc", bus.retire_pc, 32'h104);
        idle();
        chk("t2_third_pc", bus.retire_pc, 32'h108);

        // Fill all entries, refuse the extra alloc, then wrap the tail.
        do_reset();
        for (int i = 0; i < 32; i++) alloc(1'b1, 5'(i + 1), 6'(i), 6'(i + 32), 32'(i * 4));
        chk("t3_full_halt",  32'(bus.rob_halt), 32'd1);
        chk("t3_full_count", 32'(bus.count),    32'd32);
        alloc(1'b1, 5'd9, 6'd9, 6'd9, 32'hDEAD);
        chk("t3_extra_ignored", 32'(bus.count), 32'd32);
        step(1'b1, 1'b1, 5'd9, 6'd9, 6'd9, 32'hBEEF, 1'b1, 5'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 5'd9, 6'd9, 6'd9, 32'hCAFE, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t3_after_retire_halt",  32'(bus.rob_halt),  32'd0);
        chk("t3_after_retire_count", 32'(bus.count),     32'd31);
        chk("t3_wrap_tag",           32'(bus.alloc_tag), 32'd0);
        alloc(1'b1, 5'd10, 6'd10, 6'd10, 32'h1234);
        chk("t3_refull_halt", 32'(bus.rob_halt), 32'd1);

        // arch_reg 0 retires without touching the RRAT or free list.
        do_reset();
        alloc(1'b1, 5'd0, 6'd12, 6'd13, 32'h200);
        comp(5'd0, 1'b0, 32'd0);
        idle();
        chk("t4_retire_valid", 32'(bus.retire_valid),    32'd1);
        chk("t4_regwrite",     32'(bus.retire_regwrite), 32'd0);
        chk("t4_free_valid",   32'(bus.free_valid),      32'd0);

        // Mispredicted head: one-cycle flush, everything dropped, allocation restarts at tag 0.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(1'b1, 5'(i + 4), 6'(i + 20), 6'(i + 4), 32'(32'h300 + i * 4));
        comp(5'd0, 1'b1, 32'h0040_0100);
        alloc(1'b1, 5'd7, 6'd50, 6'd7, 32'h999);
        chk("t5_flush",        32'(bus.flush),        32'd1);
        chk("t5_flush_target", bus.flush_target,      32'h0040_0100);
        chk("t5_count_zero",   32'(bus.count),        32'd0);
        chk("t5_tag_zero",     32'(bus.alloc_tag),    32'd0);
        step(1'b1, 1'b1, 5'd6, 6'd51, 6'd6, 32'h500, 1'b1, 5'd3, 1'b0, 32'd0);
        chk("t5_flush_one_cycle", 32'(bus.flush), 32'd0);
        chk("t5_count_one",       32'(bus.count), 32'd1);
        idle();
        chk("t5_tag3_ignored", 32'(bus.retire_valid), 32'd0);

        // Reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 10; i++) alloc(1'b1, 5'(i + 1), 6'(i), 6'(i + 1), 32'(32'h600 + i * 4));
        comp(5'd1, 1'b0, 32'd0);
        comp(5'd0, 1'b0, 32'd0);
        idle();
        do_reset();
        chk("t6_tag_zero", 32'(bus.alloc_tag), 32'd0);
        alloc(1'b1, 5'd2, 6'd2, 6'd2, 32'h700);
        chk("t6_count_one", 32'(bus.count), 32'd1);

        // Random traffic with alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (((i / 250) % 2) == 0) r_av = ($urandom_range(3, 0) != 0);
            else                      r_av = ($urandom_range(3, 0) == 0);
            r_rw = ($urandom_range(7, 0) != 0);
            r_ar = 5'($urandom);
            r_np = 6'($urandom);
            r_op = 6'($urandom);
            r_pc = $urandom;
            r_cv = ($urandom_range(1, 0) == 1);
            if (q.size() > 0 && $urandom_range(7, 0) != 0)
                r_ct = 5'((m_head + int'($urandom_range(q.size() - 1, 0))) % 32);
            else
                r_ct = 5'($urandom);
            r_cm = ($urandom_range(39, 0) == 0);
            r_tg = $urandom;
            step(r_av, r_rw, r_ar, r_np, r_op, r_pc, r_cv, r_ct, r_cm, r_tg);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
